aes_encrypt: RTL and testbench

Iterative AES block encryptor covering AES-128/192/256 through the `Nk`/`Nr` parameters, one cipher round per clock. It takes a 128-bit plaintext and a precomputed, flattened key schedule from the upstream key-expansion block. It applies AddRoundKey, SubBytes, ShiftRows and MixColumns over `Nr+1` steps and holds the ciphertext on `state`.

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/aes_round.sv | 47 ++++
 rtl/aes_encrypt.sv | 71 +++++++
 tb/tb_aes_encrypt.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ============================================================================
// Module : aes_pkg
// Brief  : Shared AES constants, byte-level helpers and state typedef.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam int STATE_W = 128;

  // Byte 0 of the state occupies bits [127:120], so element 0 is the MSB byte.
  typedef logic [0:15][7:0] state_t;

  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_round.sv
// ============================================================================
// Module : aes_round
// Brief  : One combinational AES round: SubBytes, ShiftRows, optional
//          MixColumns (bypassed for the final round), AddRoundKey.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_round
  import aes_pkg::*;
(
  input  logic [STATE_W-1:0] state_in,
  input  logic [STATE_W-1:0] round_key,
  input  logic               skip_mix,
  output logic [STATE_W-1:0] state_out
);

  state_t st_in;
  state_t sub_sh;
  state_t mixed;

  assign st_in = state_in;

  // Output byte (row r, col c) takes the substituted byte from column c+r.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sub_sh[4*c+r] = sbox(st_in[4*((c+r)%4)+r]);
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sub_sh[4*c+0];
    assign a1 = sub_sh[4*c+1];
    assign a2 = sub_sh[4*c+2];
    assign a3 = sub_sh[4*c+3];
    assign mixed[4*c+0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mixed[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mixed[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mixed[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  assign state_out = (skip_mix ? sub_sh : mixed) ^ round_key;

endmodule

`default_nettype wire

// File: rtl/aes_encrypt.sv
// ============================================================================
// Module : aes_encrypt
// Brief  : Iterative AES-128/192/256 encryptor, one round per falling edge.
//          Optional `done` output enabled by defining AES_DONE_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_encrypt
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [STATE_W-1:0]         data,
  input  logic [(Nr+1)*STATE_W-1:0]  allKeys,
  output logic [STATE_W-1:0]         state
`ifdef AES_DONE_EN
  ,
  output logic                       done
`endif
);

  localparam int         KI_W     = $clog2(Nr + 1);
  localparam logic [5:0] RC_FIRST = 6'd1;
  localparam logic [5:0] RC_LAST  = 6'(Nr + 1);

  if (Nr != Nk + 6) begin : g_cfg_check
    $error("aes_encrypt: Nr must equal Nk+6");
  end

  logic [5:0]         rc;
  logic [KI_W-1:0]    key_idx;
  logic [STATE_W-1:0] keys [0:Nr];
  logic [STATE_W-1:0] round_out;

  for (genvar k = 0; k <= Nr; k++) begin : g_keys
    assign keys[k] = allKeys[(Nr+1)*STATE_W-1-STATE_W*k -: STATE_W];
  end

  // Only meaningful while a step is pending (rc in 1..Nr+1).
  assign key_idx = KI_W'(rc - 6'd1);

  aes_round u_round (
    .state_in  (state),
    .round_key (keys[key_idx]),
    .skip_mix  (rc == RC_LAST),
    .state_out (round_out)
  );

  always_ff @(negedge clk) begin
    if (reset) begin
      rc    <= RC_FIRST;
      state <= '0;
`ifdef AES_DONE_EN
      done  <= 1'b0;
`endif
    end else if (rc <= RC_LAST) begin
      state <= (rc == RC_FIRST) ? (data ^ keys[0]) : round_out;
      rc    <= rc + 6'd1;
`ifdef AES_DONE_EN
      done  <= (rc == RC_LAST);
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_encrypt.sv
// ============================================================================
// Module : tb_aes_encrypt
// Brief  : Self-checking bench for aes_encrypt (AES-128/192/256 instances)
//          against a GF(2^8)-arithmetic reference model; honours AES_DONE_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_encrypt;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [127:0]  data = '0;
  logic [1407:0] keys128 = '0;
  logic [1663:0] keys192 = '0;
  logic [1919:0] keys256 = '0;
  logic [127:0]  st0, st1, st2;
`ifdef AES_DONE_EN
  logic          dn0, dn1, dn2;
`endif

  int nvec = 0;
  int nerr = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] rk     [3][15];
  logic [127:0] ref_st [3][15];

  always #5 clk = ~clk;

  aes_encrypt #(.Nk(4), .Nr(10)) u_aes128 (
    .clk(clk), .reset(reset), .data(data), .allKeys(keys128), .state(st0)
`ifdef AES_DONE_EN
    , .done(dn0)
`endif
  );
  aes_encrypt #(.Nk(6), .Nr(12)) u_aes192 (
    .clk(clk), .reset(reset), .data(data), .allKeys(keys192), .state(st1)
`ifdef AES_DONE_EN
    , .done(dn1)
`endif
  );
  aes_encrypt #(.Nk(8), .Nr(14)) u_aes256 (
    .clk(clk), .reset(reset), .data(data), .allKeys(keys256), .state(st2)
`ifdef AES_DONE_EN
    , .done(dn2)
`endif
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      if (v != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
      end
      sbox_t[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sbox_t[s[127-8*(4*((c+r)%4)+r) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return o;
  endfunction

  task automatic model(input int id, input logic [255:0] key, input logic [127:0] pt);
    int           nk;
    int           nr;
    logic [31:0]  w [60];
    logic [31:0]  temp;
    logic [7:0]   rcon;
    logic [127:0] s;
    nk   = 4 + 2 * id;
    nr   = 10 + 2 * id;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      temp = w[i-1];
      if (i % nk == 0) begin
        temp = subw({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        temp = subw(temp);
      end
      w[i] = w[i-nk] ^ temp;
    end
    for (int k = 0; k <= nr; k++) rk[id][k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    s = pt ^ rk[id][0];
    ref_st[id][0] = s;
    for (int k = 1; k <= nr; k++) begin
      s = sub_shift(s);
      if (k < nr) s = mix(s);
      s = s ^ rk[id][k];
      ref_st[id][k] = s;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] dut_state(input int id);
    return (id == 0) ? st0 : (id == 1) ? st1 : st2;
  endfunction

`ifdef AES_DONE_EN
  function automatic logic dut_done(input int id);
    return (id == 0) ? dn0 : (id == 1) ? dn1 : dn2;
  endfunction
`endif

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    #1;
    for (int id = 0; id < 3; id++) begin
      chk($sformatf("reset_state id%0d", id), dut_state(id), 128'h0);
`ifdef AES_DONE_EN
      chk($sformatf("reset_done id%0d", id), {127'b0, dut_done(id)}, 128'h0);
`endif
    end
    reset = 1'b0;
  endtask

  task automatic step_edges(input int n, input int kat);
    int nr;
    for (int e = 1; e <= n; e++) begin
      @(negedge clk);
      #1;
      for (int id = 0; id < 3; id++) begin
        nr = 10 + 2 * id;
        chk($sformatf("state id%0d edge%0d", id, e), dut_state(id), ref_st[id][(e - 1 < nr) ? e - 1 : nr]);
`ifdef AES_DONE_EN
        chk($sformatf("done id%0d edge%0d", id, e), {127'b0, dut_done(id)}, {127'b0, e >= nr + 1});
`endif
      end
      if (kat == 1) begin
        if (e == 1)  chk("kat128 edge1", st0, 128'h00102030405060708090a0b0c0d0e0f0);
        if (e == 2)  chk("kat128 edge2", st0, 128'h89d810e8855ace682d1843d8cb128fe4);
        if (e == 11) chk("kat128 final", st0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        if (e == 13) chk("kat192 final", st1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
        if (e == 15) chk("kat256 final", st2, 128'h8ea2b7ca516745bfeafc49904b496089);
      end
      if (kat == 2 && e == 11) chk("kat128 zero", st0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
      // Every instance is idle by now; input changes must not disturb the result.
      if (e == 16) data = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic run_vec(input logic [255:0] key, input logic [127:0] pt,
                         input int abort_at, input int kat);
    for (int id = 0; id < 3; id++) model(id, key, pt);
    for (int k = 0; k <= 10; k++) keys128[1407-128*k -: 128] = rk[0][k];
    for (int k = 0; k <= 12; k++) keys192[1663-128*k -: 128] = rk[1][k];
    for (int k = 0; k <= 14; k++) keys256[1919-128*k -: 128] = rk[2][k];
    data = pt;
    apply_reset();
    if (abort_at > 0) begin
      step_edges(abort_at - 1, 0);
      apply_reset();
    end
    step_edges(20, kat);
  endtask

  localparam logic [255:0] KAT_KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KAT_DATA = 128'h00112233445566778899aabbccddeeff;

  initial begin
    build_sbox();
    run_vec(KAT_KEY, KAT_DATA, 0, 1);
    run_vec('0, '0, 0, 2);
    run_vec(KAT_KEY, KAT_DATA, 5, 1);
    for (int v = 0; v < 6; v++) begin
      run_vec({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom},
              (v % 2 == 1) ? int'($urandom_range(2, 14)) : 0, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
